// File: rtl/vce_pkg.sv
// Shared constants and helpers for the VCE layer mixer.
// Register indices, PRIO reset value and palette colour expansion.
package vce_pkg;

    localparam logic [4:0] REG_CPA  = 5'h01;
    localparam logic [4:0] REG_CPDW = 5'h02;
    localparam logic [4:0] REG_CPDR = 5'h03;
    localparam logic [4:0] REG_OFS0 = 5'h04;
    localparam logic [4:0] REG_PRIO = 5'h0F;

    localparam int MAX_LAYERS = 4;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    function automatic logic [15:0] prio_reset(input int layers);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < MAX_LAYERS; i++) begin
            if (i < layers) begin
                p[2*i +: 2] = 2'(i);
                p[8+i]      = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic yuv_t expand(input logic [15:0] p);
        yuv_t c;
        c.y = p[15:8];
        c.u = {p[7:4], p[6:4], p[6]};
        c.v = {p[3:0], p[2:0], p[2]};
        return c;
    endfunction

endpackage

// File: rtl/vce_layer_mixer_if.sv
// CPU register bus of the VCE layer mixer.
// master = CPU side, slave = mixer side.
interface vce_layer_mixer_if;

    logic        CE;
    logic        CSn;
    logic        WRn;
    logic        RDn;
    logic        A2;
    logic [15:0] DI;
    logic [15:0] DO;

    modport master (
        output CE, CSn, WRn, RDn, A2, DI,
        input  DO
    );

    modport slave (
        input  CE, CSn, WRn, RDn, A2, DI,
        output DO
    );

endinterface

// File: rtl/dpram.sv
// Dual-port palette RAM: port A read/write, port B read-only.
// Both reads are registered and read-first on address collision.
module dpram #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] d_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we_a) mem[addr_a] <= d_a;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/vce_prio_select.sv
// Picks the opaque layer with the highest rank.
// Ties resolve to the higher layer index.
module vce_prio_select #(
    parameter int LAYERS = 2
) (
    input  logic [9*LAYERS-1:0] vd,
    input  logic [2*LAYERS-1:0] rank,
    input  logic [LAYERS-1:0]   en,
    output logic [1:0]          win,
    output logic [8:0]          win_vd,
    output logic                valid
);

    logic [1:0] best;

    always_comb begin
        win    = '0;
        win_vd = '0;
        valid  = 1'b0;
        best   = '0;
        // ">=" lets a later (higher) layer take over on equal rank
        for (int i = 0; i < LAYERS; i++) begin
            if ((vd[9*i +: 8] != 8'd0) && en[i] &&
                (!valid || rank[2*i +: 2] >= best)) begin
                win    = 2'(i);
                win_vd = vd[9*i +: 9];
                best   = rank[2*i +: 2];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vce_layer_mixer.sv
// N-layer priority mixer with palette lookup and YUV output.
// Carries the CPU register interface for palette and mixer control.
module vce_layer_mixer
    import vce_pkg::*;
#(
    parameter int LAYERS = 2,
    parameter int PAL_AW = 9
) (
    input  logic                CLK,
    input  logic                RES,
    vce_layer_mixer_if.slave    bus,
    input  logic                PCE,
    input  logic [9*LAYERS-1:0] LAYER_VD,
    input  logic                HBL_IN,
    input  logic                VBL_IN,
    output logic [7:0]          Y,
    output logic [7:0]          U,
    output logic [7:0]          V,
    output logic                HBL,
    output logic                VBL
);

    logic [4:0]        ar;
    logic [PAL_AW-1:0] cpa;
    logic [15:0]       ofs [LAYERS];
    logic [15:0]       prio;
    logic              wr_d;
    logic              rd_d;
    logic              inc_pend;

    logic wr_strb;
    logic wr_ar;
    logic wr_dat;
    logic cpd_wr_act;
    logic cpd_wr_edge;
    logic cpd_rd_act;
    logic cpd_rd_end;

    assign wr_strb     = bus.CE & ~bus.CSn & ~bus.WRn;
    assign wr_ar       = wr_strb & ~bus.A2;
    assign wr_dat      = wr_strb & bus.A2;
    assign cpd_wr_act  = ~bus.CSn & ~bus.WRn & bus.A2
                         & (ar == REG_CPDW);
    assign cpd_wr_edge = bus.CE & cpd_wr_act & ~wr_d;
    assign cpd_rd_act  = ~bus.CSn & ~bus.RDn & bus.A2
                         & (ar == REG_CPDR);
    assign cpd_rd_end  = bus.CE & rd_d & ~cpd_rd_act
                         & ~bus.CSn & bus.RDn;

    always_ff @(posedge CLK) begin
        if (RES) begin
            ar       <= '0;
            cpa      <= '0;
            prio     <= prio_reset(LAYERS);
            wr_d     <= 1'b0;
            rd_d     <= 1'b0;
            inc_pend <= 1'b0;
            for (int i = 0; i < LAYERS; i++) ofs[i] <= '0;
        end else if (bus.CE) begin
            wr_d     <= cpd_wr_act;
            rd_d     <= cpd_rd_act;
            inc_pend <= cpd_wr_edge;
            if (inc_pend || cpd_rd_end) cpa <= cpa + 1'b1;
            if (wr_ar) ar <= bus.DI[4:0];
            if (wr_dat) begin
                // a direct CPA write overrides any increment this cycle
                if (ar == REG_CPA)  cpa  <= bus.DI[PAL_AW-1:0];
                if (ar == REG_PRIO) prio <= bus.DI;
                for (int i = 0; i < LAYERS; i++) begin
                    if (ar == REG_OFS0 + 5'(i)) ofs[i] <= bus.DI;
                end
            end
        end
    end

    logic [15:0]       pal_a;
    logic [15:0]       pal_b;
    logic [PAL_AW-1:0] mix_addr;

    dpram #(
        .AW (PAL_AW),
        .DW (16)
    ) u_pal (
        .CLK    (CLK),
        .we_a   (cpd_wr_edge),
        .addr_a (cpa),
        .d_a    (bus.DI),
        .q_a    (pal_a),
        .addr_b (mix_addr),
        .q_b    (pal_b)
    );

    logic [15:0] ofs_rd;

    always_comb begin
        ofs_rd = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (ar == REG_OFS0 + 5'(i)) ofs_rd = ofs[i];
        end
    end

    always_comb begin
        bus.DO = '0;
        if (~bus.CSn & ~bus.RDn) begin
            if (!bus.A2) begin
                bus.DO = {11'd0, ar};
            end else begin
                unique case (1'b1)
                    (ar == REG_CPA):  bus.DO = 16'(cpa);
                    (ar == REG_CPDR): bus.DO = pal_a;
                    (ar == REG_PRIO): bus.DO = prio;
                    default:          bus.DO = ofs_rd;
                endcase
            end
        end
    end

    logic [1:0]        win;
    logic [8:0]        win_vd;
    logic              win_ok;
    logic [7:0]        wofs;
    logic [PAL_AW-1:0] mix_addr_d;

    vce_prio_select #(
        .LAYERS (LAYERS)
    ) u_prio (
        .vd     (LAYER_VD),
        .rank   (prio[2*LAYERS-1:0]),
        .en     (prio[8 +: LAYERS]),
        .win    (win),
        .win_vd (win_vd),
        .valid  (win_ok)
    );

    always_comb begin
        wofs = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (win == 2'(i)) begin
                wofs = win_vd[8] ? ofs[i][15:8] : ofs[i][7:0];
            end
        end
        mix_addr_d = '0;
        if (win_ok) begin
            mix_addr_d = PAL_AW'({wofs, 1'b0})
                       + PAL_AW'(win_vd[7:0]);
        end
    end

    logic hbl1;
    logic vbl1;
    yuv_t pix_c;

    assign pix_c = expand(pal_b);

    // pal_b settles one CLK after mix_addr, before the next PCE
    always_ff @(posedge CLK) begin
        if (RES) begin
            mix_addr <= '0;
            hbl1     <= 1'b1;
            vbl1     <= 1'b1;
            Y        <= '0;
            U        <= '0;
            V        <= '0;
            HBL      <= 1'b1;
            VBL      <= 1'b1;
        end else if (PCE) begin
            mix_addr <= mix_addr_d;
            hbl1     <= HBL_IN;
            vbl1     <= VBL_IN;
            Y        <= pix_c.y;
            U        <= pix_c.u;
            V        <= pix_c.v;
            HBL      <= hbl1;
            VBL      <= vbl1;
        end
    end

endmodule

// File: tb/tb_vce_layer_mixer.sv
// Scoreboard bench for vce_layer_mixer.
// Randomised pixels and register traffic against a behavioural model.
module tb_vce_layer_mixer;

    localparam int L     = 2;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic           CLK = 1'b0;
    logic           RES = 1'b1;
    logic           PCE = 1'b0;
    logic           HBL_IN = 1'b1;
    logic           VBL_IN = 1'b1;
    logic [9*L-1:0] LAYER_VD = '0;
    logic [7:0]     Y;
    logic [7:0]     U;
    logic [7:0]     V;
    logic           HBL;
    logic           VBL;

    vce_layer_mixer_if bus_if ();

    vce_layer_mixer #(
        .LAYERS (L),
        .PAL_AW (AW)
    ) dut (
        .CLK      (CLK),
        .RES      (RES),
        .bus      (bus_if),
        .PCE      (PCE),
        .LAYER_VD (LAYER_VD),
        .HBL_IN   (HBL_IN),
        .VBL_IN   (VBL_IN),
        .Y        (Y),
        .U        (U),
        .V        (V),
        .HBL      (HBL),
        .VBL      (VBL)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [15:0] pal_m [DEPTH];
    logic [15:0] ofs_m [L];
    logic [15:0] prio_m;
    int          cpa_m;

    typedef struct {
        int   addr;
        logic hb;
        logic vb;
    } exp_t;

    exp_t sb [$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) ofs_m[i] = '0;
        prio_m = 16'h0304;
        cpa_m  = 0;
    endtask

    task automatic bus_wr(input logic a2, input logic [15:0] d);
        bus_if.CSn = 1'b0;
        bus_if.WRn = 1'b0;
        bus_if.A2  = a2;
        bus_if.DI  = d;
        tick();
        bus_if.WRn = 1'b1;
        bus_if.CSn = 1'b1;
        tick();
    endtask

    task automatic bus_rd(input logic a2, output logic [15:0] d);
        bus_if.CSn = 1'b0;
        bus_if.RDn = 1'b0;
        bus_if.A2  = a2;
        @(negedge CLK);
        d = bus_if.DO;
        tick();
        bus_if.RDn = 1'b1;
        tick();
        bus_if.CSn = 1'b1;
        tick();
    endtask

    task automatic reg_wr(input logic [4:0] idx, input logic [15:0] val);
        bus_wr(1'b0, 16'(idx));
        bus_wr(1'b1, val);
        if (idx == 5'h01) cpa_m = int'(val) % DEPTH;
        if (idx == 5'h02) begin
            pal_m[cpa_m] = val;
            cpa_m = (cpa_m + 1) % DEPTH;
        end
        if (idx >= 5'h04 && int'(idx) < 4 + L) ofs_m[int'(idx) - 4] = val;
        if (idx == 5'h0F) prio_m = val;
    endtask

    task automatic reg_rd(input logic [4:0] idx, output logic [15:0] d);
        bus_wr(1'b0, 16'(idx));
        bus_rd(1'b1, d);
        if (idx == 5'h03) cpa_m = (cpa_m + 1) % DEPTH;
    endtask

    function automatic int exp_addr(input logic [9*L-1:0] vd);
        int bk;
        int b;
        int key;
        int o;
        bk = -1;
        b  = 0;
        for (int i = 0; i < L; i++) begin
            if (vd[9*i +: 8] != 8'd0 && prio_m[8+i]) begin
                key = int'(prio_m[2*i +: 2]) * 4 + i;
                if (key > bk) begin
                    bk = key;
                    b  = i;
                end
            end
        end
        if (bk < 0) return 0;
        o = vd[9*b+8] ? int'(ofs_m[b][15:8]) : int'(ofs_m[b][7:0]);
        return (o * 2 + int'(vd[9*b +: 8])) % DEPTH;
    endfunction

    function automatic logic [25:0] exp_pix(input int a, input logic hb,
                                            input logic vb);
        logic [15:0] p;
        logic [7:0]  yy;
        logic [7:0]  uu;
        logic [7:0]  vv;
        p  = pal_m[a];
        yy = p[15:8];
        uu = 8'(p[7:4] * 16 + p[6:4] * 2 + p[6]);
        vv = 8'(p[3:0] * 16 + p[2:0] * 2 + p[2]);
        return {yy, uu, vv, hb, vb};
    endfunction

    function automatic logic [9*L-1:0] rnd_vd();
        logic [9*L-1:0] vd;
        for (int i = 0; i < L; i++) begin
            vd[9*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0
                           : 8'($urandom_range(1, 255));
            vd[9*i+8] = 1'($urandom_range(0, 1));
        end
        return vd;
    endfunction

    task automatic pix(input logic [9*L-1:0] vd, input logic hb,
                       input logic vb, input int gap);
        exp_t e;
        LAYER_VD = vd;
        HBL_IN   = hb;
        VBL_IN   = vb;
        PCE      = 1'b1;
        e.addr   = exp_addr(vd);
        e.hb     = hb;
        e.vb     = vb;
        sb.push_back(e);
        tick();
        PCE = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        exp_t e;
        RES = 1'b1;
        tick();
        chk("rst_out", 32'({Y, U, V, HBL, VBL}), 32'h3);
        bus_if.CSn = 1'b1;
        bus_if.WRn = 1'b1;
        bus_if.RDn = 1'b1;
        RES = 1'b0;
        sb.delete();
        e.addr = 0;
        e.hb   = 1'b1;
        e.vb   = 1'b1;
        sb.push_back(e);
        model_reset();
        tick();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            if (PCE && !RES) begin
                @(negedge CLK);
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pix", 32'({Y, U, V, HBL, VBL}),
                        32'(exp_pix(e.addr, e.hb, e.vb)));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        bus_if.CE  = 1'b1;
        bus_if.CSn = 1'b1;
        bus_if.WRn = 1'b1;
        bus_if.RDn = 1'b1;
        bus_if.A2  = 1'b0;
        bus_if.DI  = '0;
        model_reset();
        repeat (3) tick();
        do_reset();

        chk("do_idle", 32'(bus_if.DO), 32'h0);
        bus_rd(1'b0, d);
        chk("status_ar0", 32'(d), 32'h0);
        reg_rd(5'h0F, d);
        chk("prio_rst", 32'(d), 32'h0304);
        reg_rd(5'h01, d);
        chk("cpa_rst", 32'(d), 32'h0);
        reg_rd(5'h05, d);
        chk("ofs1_rst", 32'(d), 32'h0);
        bus_rd(1'b0, d);
        chk("status_ar5", 32'(d), 32'h5);

        reg_wr(5'h01, 16'h0000);
        for (int i = 0; i < DEPTH; i++) reg_wr(5'h02, 16'($urandom));
        reg_rd(5'h01, d);
        chk("cpa_fill_wrap", 32'(d), 32'h0);

        reg_wr(5'h01, 16'h0010);
        reg_wr(5'h02, 16'h1234);
        reg_wr(5'h02, 16'hABCD);
        reg_wr(5'h01, 16'h0010);
        reg_rd(5'h03, d);
        chk("cpd_rd0", 32'(d), 32'h1234);
        reg_rd(5'h03, d);
        chk("cpd_rd1", 32'(d), 32'hABCD);
        reg_rd(5'h01, d);
        chk("cpa_after_rd", 32'(d), 32'h012);

        reg_wr(5'h01, 16'h0020);
        bus_wr(1'b0, 16'h0002);
        bus_if.CSn = 1'b0;
        bus_if.WRn = 1'b0;
        bus_if.A2  = 1'b1;
        bus_if.DI  = 16'h5A5A;
        repeat (4) tick();
        bus_if.WRn = 1'b1;
        tick();
        bus_if.CSn = 1'b1;
        tick();
        pal_m[32'h20] = 16'h5A5A;
        cpa_m = 32'h21;
        reg_rd(5'h01, d);
        chk("cpa_held_wr", 32'(d), 32'h021);
        reg_wr(5'h01, 16'h0020);
        reg_rd(5'h03, d);
        chk("held_wr_data", 32'(d), 32'h5A5A);

        reg_wr(5'h01, 16'h01FF);
        reg_wr(5'h02, 16'hBEEF);
        reg_rd(5'h01, d);
        chk("cpa_wr_wrap", 32'(d), 32'h0);
        reg_wr(5'h01, 16'h01FF);
        reg_rd(5'h03, d);
        chk("pal_1ff", 32'(d), 32'hBEEF);
        reg_rd(5'h01, d);
        chk("cpa_rd_wrap", 32'(d), 32'h0);

        pix('0, 1'b1, 1'b1, 1);
        pix('0, 1'b1, 1'b0, 1);
        reg_wr(5'h05, 16'h1000);
        pix({9'h107, 9'h005}, 1'b0, 1'b0, 2);
        reg_wr(5'h0F, 16'h0303);
        pix({9'h107, 9'h005}, 1'b0, 1'b0, 1);
        reg_wr(5'h0F, 16'h0203);
        pix({9'h107, 9'h005}, 1'b0, 1'b0, 1);
        reg_wr(5'h04, 16'h00FF);
        reg_wr(5'h0F, 16'h0304);
        pix({9'h000, 9'h0FF}, 1'b0, 1'b1, 3);
        reg_wr(5'h0F, 16'h0300);
        pix({9'h0C3, 9'h111}, 1'b1, 1'b0, 1);
        pix('0, 1'b0, 1'b0, 1);

        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    reg_wr(5'(4 + i), 16'($urandom));
                end
            end
            reg_wr(5'h0F, {6'd0, 2'($urandom_range(0, 3)),
                           8'($urandom_range(0, 255))});
            reg_wr(5'h01, 16'($urandom_range(0, DEPTH - 1)));
            reg_wr(5'h02, 16'($urandom));
            for (int k = 0; k < 15; k++) begin
                pix(rnd_vd(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end
        end

        reg_wr(5'h01, 16'h0033);
        reg_wr(5'h02, 16'h7E57);
        for (int k = 0; k < 3; k++) pix(rnd_vd(), 1'b0, 1'b0, 1);
        bus_wr(1'b0, 16'h0002);
        bus_if.CSn = 1'b0;
        bus_if.WRn = 1'b0;
        bus_if.A2  = 1'b1;
        bus_if.DI  = 16'hC0DE;
        tick();
        pal_m[cpa_m] = 16'hC0DE;
        do_reset();
        reg_rd(5'h01, d);
        chk("cpa_no_pend", 32'(d), 32'h0);
        reg_rd(5'h0F, d);
        chk("prio_rst2", 32'(d), 32'h0304);
        reg_rd(5'h04, d);
        chk("ofs0_rst2", 32'(d), 32'h0);
        reg_wr(5'h01, 16'h0033);
        reg_rd(5'h03, d);
        chk("pal_kept0", 32'(d), 32'h7E57);
        reg_rd(5'h03, d);
        chk("pal_kept1", 32'(d), 32'hC0DE);
        for (int k = 0; k < 10; k++) pix(rnd_vd(), 1'b0, 1'b0, 1);
        pix('0, 1'b1, 1'b1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
